// File: rtl/sweep_time_counter.sv
// Sweep timer: snapshots sweep length/step period on Start, emits per-step ticks and an end pulse.
// Optional macro SWEEP_DIR_EN adds a Dir output that toggles at each continuous-mode sweep end.
module sweep_time_counter #(
    parameter int TIME_W = 48,
    parameter int STEP_W = 16,
    parameter int CNT_W  = 16
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [TIME_W-1:0] Time_Value,
    input  logic [STEP_W-1:0] Step_Period,
    input  logic              Start,
    input  logic              Stop,
    input  logic              Continuous,
    output logic              Busy,
    output logic              Step_Tick,
    output logic              Sweep_End,
    output logic [TIME_W-1:0] Elapsed,
    output logic [CNT_W-1:0]  Sweep_Cnt,
    output logic              Dir
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [TIME_W-1:0] t_s_q, t_s_d;
    logic [STEP_W-1:0] p_s_q, p_s_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic [TIME_W-1:0] elapsed_q, elapsed_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              tick_q, tick_d;
    logic              end_q, end_d;

    logic              tv_nonzero;
    logic              start_ok;
    logic [STEP_W-1:0] p_in;
    logic              last_cycle;
    logic              step_hit;

    assign tv_nonzero = (Time_Value != '0);
    assign start_ok   = Start && !Stop && tv_nonzero;
    // A zero step period would never tick; treat it as one step per cycle.
    assign p_in       = (Step_Period == '0) ? STEP_W'(1) : Step_Period;
    // Elapsed tops out at T_s-1, so the edge after that is the sweep boundary.
    assign last_cycle = (elapsed_q == (t_s_q - TIME_W'(1)));
    assign step_hit   = (step_q == (p_s_q - STEP_W'(1)));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= ST_IDLE;
            t_s_q     <= '0;
            p_s_q     <= '0;
            step_q    <= '0;
            elapsed_q <= '0;
            cnt_q     <= '0;
            tick_q    <= 1'b0;
            end_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            t_s_q     <= t_s_d;
            p_s_q     <= p_s_d;
            step_q    <= step_d;
            elapsed_q <= elapsed_d;
            cnt_q     <= cnt_d;
            tick_q    <= tick_d;
            end_q     <= end_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        t_s_d     = t_s_q;
        p_s_d     = p_s_q;
        step_d    = step_q;
        elapsed_d = elapsed_q;
        cnt_d     = cnt_q;
        tick_d    = 1'b0;
        end_d     = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d   = ST_RUN;
                    t_s_d     = Time_Value;
                    p_s_d     = p_in;
                    elapsed_d = '0;
                    step_d    = '0;
                    cnt_d     = '0;
                end
            end
            ST_RUN: begin
                if (Stop) begin
                    // Abort: Elapsed and Sweep_Cnt keep their last values for inspection.
                    state_d = ST_IDLE;
                end else if (last_cycle) begin
                    end_d = 1'b1;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (Continuous && tv_nonzero) begin
                        t_s_d     = Time_Value;
                        p_s_d     = p_in;
                        elapsed_d = '0;
                        step_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    elapsed_d = elapsed_q + TIME_W'(1);
                    if (step_hit) begin
                        tick_d = 1'b1;
                        step_d = '0;
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign Busy      = (state_q == ST_RUN);
    assign Step_Tick = tick_q;
    assign Sweep_End = end_q;
    assign Elapsed   = elapsed_q;
    assign Sweep_Cnt = cnt_q;

`ifdef SWEEP_DIR_EN
    logic dir_q, dir_d;

    always_comb begin
        dir_d = dir_q;
        if (state_q == ST_IDLE) begin
            if (start_ok) begin
                dir_d = 1'b0;
            end
        end else if (!Stop && last_cycle && Continuous) begin
            dir_d = ~dir_q;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            dir_q <= 1'b0;
        end else begin
            dir_q <= dir_d;
        end
    end

    assign Dir = dir_q;
`else
    assign Dir = 1'b0;
`endif

endmodule

// File: tb/tb_sweep_time_counter.sv
// Self-checking bench for sweep_time_counter: per-cycle vectors with a scoreboard queue.
module tb_sweep_time_counter;

`ifdef SWEEP_DIR_EN
    localparam bit DIR_EN = 1'b1;
`else
    localparam bit DIR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic [47:0] time_value;
    logic [15:0] step_period;
    logic        start;
    logic        stop;
    logic        continuous;
    logic        busy;
    logic        step_tick;
    logic        sweep_end;
    logic [47:0] elapsed;
    logic [15:0] sweep_cnt;
    logic        dir;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        start;
        logic        stop;
        logic        cont;
        logic [47:0] tv;
        logic [15:0] sp;
        logic        busy;
        logic        tick;
        logic        send;
        logic        chk_el;
        logic [47:0] el;
        logic [15:0] cnt;
        logic        dir;
    } vec_t;

    vec_t exp_q[$];

    sweep_time_counter #(.TIME_W(48), .STEP_W(16), .CNT_W(16)) dut (
        .Clock      (clk),
        .Reset      (rst),
        .Time_Value (time_value),
        .Step_Period(step_period),
        .Start      (start),
        .Stop       (stop),
        .Continuous (continuous),
        .Busy       (busy),
        .Step_Tick  (step_tick),
        .Sweep_End  (sweep_end),
        .Elapsed    (elapsed),
        .Sweep_Cnt  (sweep_cnt),
        .Dir        (dir)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input bit st, input bit sp_, input bit ct, input logic [47:0] tv,
                                input logic [15:0] per, input bit b, input bit tk, input bit en,
                                input bit ce, input logic [47:0] el, input logic [15:0] cnt,
                                input bit d);
        vec_t v;
        v.start = st; v.stop = sp_; v.cont = ct; v.tv = tv; v.sp = per;
        v.busy = b; v.tick = tk; v.send = en; v.chk_el = ce; v.el = el; v.cnt = cnt; v.dir = d;
        return v;
    endfunction

    task automatic cmp(input string tag, input string name, input logic [63:0] act,
                       input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s %s: got %0d, expected %0d", tag, name, act, req);
        end
    endtask

    // Drive one cycle of stimulus, then compare the registered outputs after the edge.
    task automatic apply(input string tag, input vec_t v);
        vec_t e;
        @(negedge clk);
        start       = v.start;
        stop        = v.stop;
        continuous  = v.cont;
        time_value  = v.tv;
        step_period = v.sp;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue, expected an entry", tag);
        end else begin
            e = exp_q.pop_front();
            cmp(tag, "busy", 64'(busy), 64'(e.busy));
            cmp(tag, "step_tick", 64'(step_tick), 64'(e.tick));
            cmp(tag, "sweep_end", 64'(sweep_end), 64'(e.send));
            cmp(tag, "sweep_cnt", 64'(sweep_cnt), 64'(e.cnt));
            cmp(tag, "dir", 64'(dir), 64'(e.dir));
            if (e.chk_el) cmp(tag, "elapsed", 64'(elapsed), 64'(e.el));
            $display("%s: busy=%0b tick=%0b end=%0b elapsed=%0d cnt=%0d dir=%0b",
                     tag, busy, step_tick, sweep_end, elapsed, sweep_cnt, dir);
        end
    endtask

    task automatic check_all_zero(input string tag);
        cmp(tag, "busy", 64'(busy), 64'd0);
        cmp(tag, "step_tick", 64'(step_tick), 64'd0);
        cmp(tag, "sweep_end", 64'(sweep_end), 64'd0);
        cmp(tag, "elapsed", 64'(elapsed), 64'd0);
        cmp(tag, "sweep_cnt", 64'(sweep_cnt), 64'd0);
        cmp(tag, "dir", 64'(dir), 64'd0);
        $display("%s: busy=%0b tick=%0b end=%0b elapsed=%0d cnt=%0d dir=%0b",
                 tag, busy, step_tick, sweep_end, elapsed, sweep_cnt, dir);
    endtask

    vec_t t1[13];

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0;
        time_value = '0; step_period = '0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // T=10, P=4 single shot; a second Start mid-sweep must be ignored.
        for (int i = 0; i < 13; i++) begin
            if (i <= 9)
                t1[i] = mk(i == 0 || i == 5, 0, 0, 48'd10, 16'd4, 1, (i == 4 || i == 8), 0,
                           1, 48'(i), 16'd0, 0);
            else
                t1[i] = mk(0, 0, 0, 48'd10, 16'd4, 0, 0, (i == 10), 0, 48'd0, 16'd1, 0);
        end
        for (int i = 0; i < 13; i++) apply($sformatf("t1[%0d]", i), t1[i]);

        // T=8, P=4: the tick coinciding with sweep end is suppressed.
        for (int j = 0; j <= 8; j++) begin
            if (j < 8)
                apply($sformatf("t2[%0d]", j),
                      mk(j == 0, 0, 0, 48'd8, 16'd4, 1, (j == 4), 0, 1, 48'(j), 16'd0, 0));
            else
                apply($sformatf("t2[%0d]", j),
                      mk(0, 0, 0, 48'd8, 16'd4, 0, 0, 1, 0, 48'd0, 16'd1, 0));
        end

        // T=6, P=3 continuous; Time_Value drops to 4 mid-sweep, taking effect at the boundary.
        for (int j = 0; j <= 16; j++) begin
            logic [47:0] tv;
            logic [47:0] el;
            logic [15:0] cnt;
            bit tk, en, b, d;
            tv = (j <= 2) ? 48'd6 : 48'd4;
            b = (j <= 14);
            en = (j == 6 || j == 10 || j == 14);
            tk = (j == 3 || j == 9 || j == 13);
            if (j < 6)       begin el = 48'(j);      cnt = 16'd0; d = 0; end
            else if (j < 10) begin el = 48'(j - 6);  cnt = 16'd1; d = 1; end
            else if (j < 14) begin el = 48'(j - 10); cnt = 16'd2; d = 0; end
            else             begin el = 48'd0;       cnt = 16'd3; d = 1; end
            apply($sformatf("t3[%0d]", j),
                  mk(j == 0, j == 15, 1, tv, 16'd3, b, tk, en, 1, el, cnt, d & DIR_EN));
        end

        // Start with Time_Value=0 is ignored; outputs keep their values.
        for (int j = 0; j < 3; j++)
            apply($sformatf("t4z[%0d]", j),
                  mk(1, 0, 0, 48'd0, 16'd2, 0, 0, 0, 1, 48'd0, 16'd3, DIR_EN));
        // Step_Period=0 behaves as 1.
        for (int j = 0; j <= 3; j++) begin
            if (j < 3)
                apply($sformatf("t4p[%0d]", j),
                      mk(j == 0, 0, 0, 48'd3, 16'd0, 1, (j >= 1), 0, 1, 48'(j), 16'd0, 0));
            else
                apply($sformatf("t4p[%0d]", j),
                      mk(0, 0, 0, 48'd3, 16'd0, 0, 0, 1, 0, 48'd0, 16'd1, 0));
        end

        // Stop mid-sweep, then Start+Stop together from IDLE.
        for (int j = 0; j <= 9; j++) begin
            if (j <= 5)
                apply($sformatf("t5[%0d]", j),
                      mk(j == 0, 0, 0, 48'd10, 16'd4, 1, (j == 4), 0, 1, 48'(j), 16'd0, 0));
            else
                apply($sformatf("t5[%0d]", j),
                      mk(j == 8, (j == 6 || j == 8), 0, 48'd10, 16'd4, 0, 0, 0, 1, 48'd5, 16'd0, 0));
        end

        // Asynchronous reset in the middle of a sweep.
        for (int j = 0; j < 3; j++)
            apply($sformatf("t6[%0d]", j),
                  mk(j == 0, 0, 0, 48'd10, 16'd1, 1, (j >= 1), 0, 1, 48'(j), 16'd0, 0));
        @(negedge clk);
        start = 1'b0;
        #1 rst = 1'b1;
        #1 check_all_zero("t6_async_reset");
        @(negedge clk);
        rst = 1'b0;
        apply("t6_after", mk(0, 0, 0, 48'd10, 16'd1, 0, 0, 0, 1, 48'd0, 16'd0, 0));

`ifdef SWEEP_DIR_EN
        // Continuous T=4, P=2: Dir toggles at every sweep end and holds on Stop.
        for (int j = 0; j <= 9; j++) begin
            logic [15:0] cnt;
            bit d;
            cnt = (j < 4) ? 16'd0 : (j < 8) ? 16'd1 : 16'd2;
            d = (j >= 4 && j < 8);
            apply($sformatf("t7[%0d]", j),
                  mk(j == 0, j == 9, 1, 48'd4, 16'd2, (j <= 8), (j == 2 || j == 6),
                     (j == 4 || j == 8), (j <= 8), 48'(j % 4), cnt, d));
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
